// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the two-master memory arbiter.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default bus widths
//   ALIGN_MASK                      : value addr[1:0] must hold for a word access
//   state_t                         : transaction FSM states
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [1:0] ALIGN_MASK = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin grant.
//   i_req[1:0]   : request from master 1 / master 0
//   i_lastGrant  : master granted most recently (0 = m0, 1 = m1)
//   o_grant[1:0] : one-hot grant, all zero when nobody requests
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_lastGrant,
    output logic [1:0] o_grant
);

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_lastGrant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous memory port between two masters, one transaction
// at a time, using round-robin arbitration. Each transaction takes three
// cycles: IDLE (grant + latch), ISSUE (drive bus), RESP (ack).
//   clk, reset (async, active low)
//   m0_*/m1_*  : req, we, addr, wdata in; ack, rdata, err out
//   address, dataOut, busWriteEnable : memory bus outputs
//   dataIn     : memory read data, registered by the memory
// ---------------------------------------------------------------------------
module mem_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = bus_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = bus_pkg::DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  busWriteEnable,
    input  logic [DATA_WIDTH-1:0] dataIn
);

    state_t                r_state;
    // Last-grant bit doubles as the in-flight winner: it only changes on
    // the IDLE->ISSUE edge, so during ISSUE/RESP it names the owner.
    logic                  r_lastGrant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [1:0]            w_grant;
    logic                  w_inIssue;
    logic                  w_inResp;
    logic                  w_aligned;
    logic                  w_ack0;
    logic                  w_ack1;
    logic                  w_readOk;

    rr_arbiter2 u_rrArbiter (
        .i_req       ({m1_req, m0_req}),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_grant)
    );

    // Reset prefers m0 on the first tie by pretending m1 won last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_lastGrant <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_state     <= ISSUE;
                        r_lastGrant <= w_grant[1];
                        r_we        <= w_grant[1] ? m1_we    : m0_we;
                        r_addr      <= w_grant[1] ? m1_addr  : m0_addr;
                        r_wdata     <= w_grant[1] ? m1_wdata : m0_wdata;
                    end
                end
                ISSUE:   r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them
    // (including busWriteEnable) in the same instant.
    assign w_inIssue = (r_state == ISSUE);
    assign w_inResp  = (r_state == RESP);
    assign w_aligned = (r_addr[1:0] == ALIGN_MASK);

    assign address        = w_inIssue ? r_addr  : '0;
    assign dataOut        = w_inIssue ? r_wdata : '0;
    assign busWriteEnable = w_inIssue & r_we & w_aligned;

    assign w_ack0   = w_inResp & ~r_lastGrant;
    assign w_ack1   = w_inResp &  r_lastGrant;
    assign w_readOk = ~r_we & w_aligned;

    assign m0_ack   = w_ack0;
    assign m1_ack   = w_ack1;
    assign m0_err   = w_ack0 & ~w_aligned;
    assign m1_err   = w_ack1 & ~w_aligned;
    assign m0_rdata = (w_ack0 && w_readOk) ? dataIn : '0;
    assign m1_rdata = (w_ack1 && w_readOk) ? dataIn : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32: word width on all data ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m0_req / m1_req  input  1  requester n wants one bus transaction; held until its ack.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 m0_addr / m1_addr  input  ADDR_WIDTH  byte address; must be word aligned.
REQ-008 m0_wdata / m1_wdata  input  DATA_WIDTH  write data.
REQ-009 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-010 m0_rdata / m1_rdata  output  DATA_WIDTH  read data, valid only while the matching ack is high.
REQ-011 m0_err / m1_err  output  1  high with ack when the transaction was unaligned.
REQ-012 address  output  ADDR_WIDTH  memory bus address.
REQ-013 dataOut  output  DATA_WIDTH  memory bus write data.
REQ-014 busWriteEnable  output  1  1 = write, 0 = read.
REQ-015 dataIn  input  DATA_WIDTH  memory read data, registered by memory one cycle after address.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; each transaction takes exactly 3 cycles (IDLE, ISSUE, RESP); req-sampled-to-ack latency is 2 edges.
REQ-017 IDLE: if any req is sampled high, select a winner, latch its we/addr/wdata into internal registers, and go to ISSUE; otherwise stay in IDLE.
REQ-018 Arbitration: round-robin. A lone requester wins. If both request, the master not granted last wins.
REQ-019 ISSUE: drive address/dataOut/busWriteEnable from the latched registers. busWriteEnable is high only in ISSUE, and only for aligned writes. Then go to RESP.
REQ-020 RESP: assert the winner's ack for one cycle. rdata = dataIn for reads and 0 for writes. Then go to IDLE unconditionally.
REQ-021 A req still high in RESP belongs to the finishing transaction and is ignored. A new transaction can start no earlier than the following IDLE edge.
REQ-022 Master inputs changing after the grant edge have no effect on the in-flight transaction.
REQ-023 Unaligned transaction (addr[1:0] != 0):
- address is still driven;
- busWriteEnable stays 0;
- RESP gives ack=1, err=1, rdata=0.
REQ-024 The non-winning master's ack, err and rdata are 0 in every cycle.
REQ-025 address, dataOut and busWriteEnable are 0 in IDLE and RESP.
REQ-026 If req drops before ack, the transaction still completes and the ack pulse is still issued.

Reset
REQ-027 On reset low, immediately and asynchronously:
- state = IDLE;
- all outputs = 0;
- latched registers cleared;
- last-grant = m1, so m0 wins the first tie.
REQ-028 Reset asserted in ISSUE or RESP aborts the transaction: no ack is issued, and busWriteEnable drops the same instant.
REQ-029 After reset deasserts, the first req can be sampled on the next rising edge.

Structure
REQ-030 Shared package bus_pkg holds:
- state enum (IDLE, ISSUE, RESP);
- ADDR_WIDTH and DATA_WIDTH defaults;
- word-alignment mask constant 2'b00.
REQ-031 One sub-module, rr_arbiter2: combinational 2-way round-robin grant from req[1:0] and a last-grant bit. The last-grant register stays in mem_arbiter and updates only on the IDLE->ISSUE edge.

Verification
REQ-032 Memory model: 1024-word array, write on posedge when busWriteEnable is high, dataIn registered from the array at address[11:2].
REQ-033 m0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> write ack 2 edges after req, read ack with m0_rdata=0xDEADBEEF, m0_err=0.
REQ-034 m0 and m1 request in the same cycle from reset, both held -> m0 acked first, m1 three cycles later, then m0 again, alternating.
REQ-035 m1 writes 0x12345678 to 0x22 (unaligned) -> busWriteEnable never high, m1_ack=1, m1_err=1, m1_rdata=0, memory word 8 unchanged.
REQ-036 m0 write to 0x40 with reset pulsed low during ISSUE -> busWriteEnable drops at once, no m0_ack, state IDLE, next tie grants m0.
REQ-037 m1 read of 0x40 issued, m1_addr changed to 0x80 after the grant edge -> memory address 0x40 used, m1_rdata equals word 16.
REQ-038 m0 holds req continuously for 6 transactions -> exactly one ack per 3 cycles, no ack in consecutive cycles.
